// File: rtl/video_pattern_sequencer.sv
// Test-pattern scheduler: counts frames, auto-advances the pattern every HOLD_FRAMES
// frames and applies manual requests, with every change landing on a frame boundary.
module video_pattern_sequencer #(
    parameter int NUM_PATTERNS = 8,
    parameter int PATW         = 3,
    parameter int HOLD_FRAMES  = 120,
    parameter int FCW          = 16
) (
    input  logic            video_clk_pix,
    input  logic            video_rst,
    input  logic            frame_start,
    input  logic            auto_en,
    input  logic            req_valid,
    input  logic [PATW-1:0] req_pattern,
    output logic            req_ready,
    output logic [PATW-1:0] pattern_sel,
    output logic            pattern_change,
    output logic [FCW-1:0]  frame_count,
    output logic            busy
);

    localparam int              HCW       = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_FRAMES - 1);
    localparam logic [PATW-1:0] LAST_PAT  = PATW'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        RUN,
        PEND
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PATW-1:0] r_pattern_sel;
    logic [PATW-1:0] w_next_sel;
    logic [PATW-1:0] r_pend;
    logic [PATW-1:0] w_next_pend;
    logic [HCW-1:0]  r_hold_cnt;
    logic [HCW-1:0]  w_next_hold;
    logic            w_change;
    logic            r_pattern_change;
    logic            r_req_ready;
    logic            r_busy;
    logic [FCW-1:0]  r_frame_count;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_pattern_sel;
        w_next_pend  = r_pend;
        w_next_hold  = r_hold_cnt;
        w_change     = 1'b0;
        unique case (r_state)
            WAIT_SYNC: begin
                if (frame_start) begin
                    w_next_state = RUN;
                    w_next_hold  = '0;
                end
            end
            RUN: begin
                // Auto rule is judged on this frame even if a request is accepted now.
                if (frame_start) begin
                    if (!auto_en) begin
                        w_next_hold = '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        w_next_sel  = (r_pattern_sel == LAST_PAT) ? '0 : r_pattern_sel + PATW'(1);
                        w_change    = 1'b1;
                        w_next_hold = '0;
                    end else begin
                        w_next_hold = r_hold_cnt + HCW'(1);
                    end
                end
                if (req_valid && r_req_ready) begin
                    w_next_pend  = (req_pattern > LAST_PAT) ? LAST_PAT : req_pattern;
                    w_next_state = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    w_next_sel   = r_pend;
                    w_change     = 1'b1;
                    w_next_hold  = '0;
                    w_next_state = RUN;
                end
            end
            default: w_next_state = WAIT_SYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge video_clk_pix) begin
        if (video_rst) begin
            r_state          <= WAIT_SYNC;
            r_pattern_sel    <= '0;
            r_pattern_change <= 1'b0;
            r_pend           <= '0;
            r_hold_cnt       <= '0;
            r_req_ready      <= 1'b0;
            r_busy           <= 1'b1;
            r_frame_count    <= '0;
        end else begin
            r_state          <= w_next_state;
            r_pattern_sel    <= w_next_sel;
            r_pattern_change <= w_change;
            r_pend           <= w_next_pend;
            r_hold_cnt       <= w_next_hold;
            r_req_ready      <= (w_next_state == RUN);
            r_busy           <= (w_next_state != RUN);
            if (frame_start) begin
                r_frame_count <= r_frame_count + FCW'(1);
            end
        end
    end

    assign req_ready      = r_req_ready;
    assign pattern_sel    = r_pattern_sel;
    assign pattern_change = r_pattern_change;
    assign frame_count    = r_frame_count;
    assign busy           = r_busy;

endmodule
